// File: rtl/alu_seq_ctrl.sv
// Multi-cycle integer ALU sequencer: single-cycle add/sub, iterative shift-add mul, restoring div.
// Optional macro ALU_SEQ_EARLY_EXIT_EN: mul finishes as soon as the remaining multiplier bits are zero.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6    // 2**CNT_W must exceed WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             div_zero
);

    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        ITER,
        FINISH
    } state_t;

    state_t           state;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;

    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] acc_step;
    logic [WIDTH-1:0] mplier_step;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;

    // One iteration of each engine plus the single-cycle datapath
    always_comb begin
        mul_sum     = {1'b0, acc[ACC_W-1:WIDTH]} + (mplier[0] ? {1'b0, a_r} : (WIDTH+1)'(0));
        acc_step    = {mul_sum, acc[WIDTH-1:1]};
        mplier_step = mplier >> 1;
        rem_shift   = {rem, quo[WIDTH-1]};
        trial       = rem_shift - {1'b0, b_r};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b0};
        end
        add_full = {1'b0, a_r} + {1'b0, b_r};
        sub_full = {1'b0, a_r} - {1'b0, b_r};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carry_out <= 1'b0;
            div_zero  <= 1'b0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            acc       <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // busy is still high on the done cycle, so a start there is dropped
                IDLE: begin
                    if (start && !busy) begin
                        busy   <= 1'b1;
                        op_r   <= op;
                        a_r    <= a;
                        b_r    <= b;
                        cnt    <= '0;
                        acc    <= '0;
                        mplier <= b;
                        rem    <= '0;
                        quo    <= a;
                        if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                            state <= ITER;
                        end else begin
                            state <= SINGLE;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SINGLE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    case (op_r)
                        OP_SUB: begin
                            result    <= sub_full[WIDTH-1:0];
                            result_hi <= '0;
                            carry_out <= sub_full[WIDTH];
                            div_zero  <= 1'b0;
                        end
                        OP_DIV: begin
                            result    <= '1;
                            result_hi <= a_r;
                            carry_out <= 1'b0;
                            div_zero  <= 1'b1;
                        end
                        default: begin
                            result    <= add_full[WIDTH-1:0];
                            result_hi <= '0;
                            carry_out <= add_full[WIDTH];
                            div_zero  <= 1'b0;
                        end
                    endcase
                end
                ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= FINISH;
                    end
                    if (op_r == OP_MUL) begin
                        acc    <= acc_step;
                        mplier <= mplier_step;
`ifdef ALU_SEQ_EARLY_EXIT_EN
                        // Nothing left to add: apply the remaining shifts at once
                        if (mplier_step == '0) begin
                            acc   <= acc_step >> (LAST_CNT - cnt);
                            state <= FINISH;
                        end
`endif
                    end else begin
                        rem <= rem_step;
                        quo <= quo_step;
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    state     <= IDLE;
                    carry_out <= 1'b0;
                    div_zero  <= 1'b0;
                    if (op_r == OP_MUL) begin
                        result    <= acc[WIDTH-1:0];
                        result_hi <= acc[ACC_W-1:WIDTH];
                    end else begin
                        result    <= quo;
                        result_hi <= rem;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed table-driven bench for alu_seq_ctrl (WIDTH=32), plus reset/abort sequences.
module tb_alu_seq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int NV = 14;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    localparam int LAT_MUL_B1   = 3;
    localparam int LAT_MUL_B100 = 11;
    localparam int LAT_MUL_B0   = 3;
`else
    localparam int LAT_MUL_B1   = 34;
    localparam int LAT_MUL_B100 = 34;
    localparam int LAT_MUL_B0   = 34;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry_out;
    logic             div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .carry_out(carry_out), .div_zero(div_zero)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        carry;
        logic        dz;
        int          lat;
        bit          poke;
    } vec_t;

    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Apply one vector; optionally raise start again on the done cycle
    task automatic run_vec(input int i, input bit at_done);
        int lat;
        int extra;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
        @(negedge clk);
        start = 1'b0; op = 4'h1; a = ~a; b = ~b;
        lat = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (vecs[i].poke && lat == 10) begin
                    start = 1'b1; op = 4'h0; a = 32'd1; b = 32'd1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        chk($sformatf("v%0d_done_seen", i), 64'(seen), 64'd1);
        chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        chk($sformatf("v%0d_busy_held", i), 64'(busy_ok), 64'd1);
        chk($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].res));
        chk($sformatf("v%0d_result_hi", i), 64'(result_hi), 64'(vecs[i].hi));
        chk($sformatf("v%0d_carry", i), 64'(carry_out), 64'(vecs[i].carry));
        chk($sformatf("v%0d_div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
        if (at_done) begin
            start = 1'b1; op = 4'h0; a = 32'd2; b = 32'd2;
        end
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_done_single", i), 64'(done), 64'd0);
        chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
        chk($sformatf("v%0d_result_hold", i), 64'(result), 64'(vecs[i].res));
        if (at_done) begin
            extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) extra++;
            end
            chk($sformatf("v%0d_start_on_done_ignored", i), 64'(extra), 64'd0);
        end
    endtask

    initial begin
        int dn;
        vecs[0]  = '{4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 1'b0, 2,  1'b0};
        vecs[1]  = '{4'h1, 32'd5,        32'd7,        32'hFFFFFFFE, 32'h0,        1'b1, 1'b0, 2,  1'b0};
        vecs[2]  = '{4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 1'b0, 34, 1'b1};
        vecs[3]  = '{4'h3, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 34, 1'b0};
        vecs[4]  = '{4'h3, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b1, 2,  1'b0};
        vecs[5]  = '{4'h2, 32'd6,        32'd1,        32'd6,        32'h0,        1'b0, 1'b0, LAT_MUL_B1, 1'b0};
        vecs[6]  = '{4'h1, 32'd10,       32'd3,        32'd7,        32'h0,        1'b0, 1'b0, 2,  1'b0};
        vecs[7]  = '{4'h2, 32'h12345678, 32'h100,      32'h34567800, 32'h12,       1'b0, 1'b0, LAT_MUL_B100, 1'b0};
        vecs[8]  = '{4'h3, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0, 1'b0, 34, 1'b0};
        vecs[9]  = '{4'h0, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        1'b1, 1'b0, 2,  1'b0};
        vecs[10] = '{4'h2, 32'd5,        32'd0,        32'h0,        32'h0,        1'b0, 1'b0, LAT_MUL_B0, 1'b0};
        vecs[11] = '{4'h3, 32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 1'b0, 34, 1'b0};
        vecs[12] = '{4'h3, 32'd7,        32'd7,        32'd1,        32'd0,        1'b0, 1'b0, 34, 1'b0};
        vecs[13] = '{4'h7, 32'd3,        32'd4,        32'd7,        32'h0,        1'b0, 1'b0, 2,  1'b0};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_outputs", {result, result_hi}, 64'd0);
        chk("reset_flags", 64'({carry_out, div_zero}), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV - 1; i++) begin
            run_vec(i, i == 0);
        end

        // Abort a multiply with reset partway through
        @(negedge clk);
        start = 1'b1; op = 4'h2; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (14) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if (done === 1'b1) dn++;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_outputs", {result, result_hi}, 64'd0);
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);

        run_vec(NV - 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer wrapped around the CPU's integer ALU operations.
- Add and subtract complete in a single cycle.
- Multiply uses an iterative unsigned shift-add engine; divide uses an iterative unsigned restoring divider. This replaces the single-cycle `*` and `/` paths.
- Sits between decode/issue and writeback; the CPU stalls while `busy` is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only when busy=0.
- op  input  4  0000 add, 0001 sub, 0010 mul, 0011 div; any other code executes add.
- a  input  WIDTH  operand A (dividend / multiplicand).
- b  input  WIDTH  operand B (divisor / multiplier).
- busy  output  1  high from the cycle after accept until the done cycle, inclusive.
- done  output  1  one-cycle pulse; result fields valid on this cycle.
- result  output  WIDTH  sum, difference, low product, or quotient.
- result_hi  output  WIDTH  high product or remainder; 0 for add/sub.
- carry_out  output  1  add: carry of a+b. sub: borrow (a<b). mul/div: 0.
- div_zero  output  1  high with done when a div had b=0.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy, done, carry_out, div_zero = 0; result, result_hi = 0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, SINGLE, ITER, FINISH.
- IDLE:
  - start=1 latches a, b, op and sets busy=1 next cycle.
  - add/sub/default → SINGLE.
  - mul → ITER, with cnt=0, acc=0, mcand=a, mplier=b.
  - div with b≠0 → ITER, with rem=0, quo=a, cnt=0.
  - div with b=0 → SINGLE.
- SINGLE:
  - Compute result, register outputs, pulse done. Next state IDLE, busy=0 the following cycle.
  - Latency from accept edge to done: 2 cycles.
  - div by zero: result=all ones, result_hi=a, div_zero=1.
- ITER: one step per cycle, cnt increments; leave after WIDTH steps (cnt==WIDTH-1 → FINISH).
  - mul step: if mplier[0], add mcand into the upper half of a 2·WIDTH accumulator (with carry); shift accumulator and mplier right by 1.
  - div step: shift {rem,quo} left by 1; trial = rem - b; if trial is non-negative, rem=trial and quo[0]=1.
- FINISH:
  - Drive result/result_hi from the accumulator (mul) or quo/rem (div); pulse done; → IDLE.
  - Latency from accept edge to done: WIDTH+2 cycles (34 for WIDTH=32).
- Arithmetic:
  - All operations are unsigned and modulo 2^WIDTH.
  - The mul product is the full 2·WIDTH bits, split across result_hi:result.
- Holds and ignored inputs:
  - result, result_hi, carry_out and div_zero hold their value until the next done.
  - done is never asserted for 2 consecutive cycles.
  - start while busy=1 is ignored; the request is not queued and not lost-flagged.
  - start on the same cycle that done is high is ignored, because busy=1 that cycle.
  - Operand and op changes after accept have no effect.

Optional Feature:
- Macro: ALU_SEQ_EARLY_EXIT_EN.
- Defined: in mul ITER, if the remaining mplier bits are all zero, jump to FINISH and shift the accumulator right by the remaining (WIDTH-cnt) positions in one step.
  - Latency becomes (index of the highest set bit of b) + 3.
  - mul with b=0 gives done 3 cycles after accept.
  - div is unaffected.
- Undefined: fixed WIDTH+2 latency for every mul.

Test Plan:
- Reset values and start:
  - Assert reset for 2 cycles → all outputs 0, busy=0.
  - Then start op=0000, a=0xFFFFFFFF, b=1 → done at +2 with result=0, carry_out=1, result_hi=0.
- Subtract with borrow: op=0001, a=5, b=7 → result=0xFFFFFFFE, carry_out=1, done at +2.
- Multiply:
  - op=0010, a=0xFFFFFFFF, b=0xFFFFFFFF → done at +34, result=0x00000001, result_hi=0xFFFFFFFE.
  - busy stays high for 34 cycles.
  - A start pulse at +10 is ignored.
- Divide:
  - op=0011, a=100, b=7 → done at +34, result=14, result_hi=2, div_zero=0.
  - op=0011, a=9, b=0 → done at +2, result=0xFFFFFFFF, result_hi=9, div_zero=1.
- Reset mid-operation and unknown op:
  - Start mul, assert reset at cycle +15 → no done, busy=0 next cycle.
  - Then start op=0111, a=3, b=4 → result=7.
- Early exit: with ALU_SEQ_EARLY_EXIT_EN defined, mul a=6, b=1 → done at +3, result=6; without the macro, done at +34.
